dac_sample_fifo: RTL

- Downstream stage of the UDP packet receiver. Consumes the 32-bit payload words that the receiver strobes out for the DAC port.
- Buffers the words in a block-RAM FIFO and releases one I/Q sample pair per DAC sample-enable pulse.
- Primes before playback, detects underrun and overflow, and holds the DAC at a defined value when starved.
- Sits between the packet receiver and the DAC output register/serializer, all in the single system clock domain.

---
 rtl/dac_sample_fifo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: block-RAM sample buffer between the UDP packet receiver
// and the DAC output register. Payload words ([31:16] = I, [15:0] = Q)
// are queued and released one pair per sample_en_i tick once the FIFO has
// primed to START_LEVEL. Starvation is flagged and parks the DAC outputs.
//
// Build option:
//   DAC_FIFO_HOLD_LAST_EN - when defined, the outputs keep the last sample
//   on underrun; when undefined, they drop to 16'h0000 (mid-scale silence).
module dac_sample_fifo #(
  parameter int ADDR_WIDTH  = 10,
  parameter int START_LEVEL = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  flush_i,
  input  logic                  sample_en_i,
  output logic [15:0]           dac_i_o,
  output logic [15:0]           dac_q_o,
  output logic                  dac_valid_o,
  output logic                  running_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] START_LVL = (ADDR_WIDTH + 1)'(START_LEVEL);

  typedef enum logic [2:0] {
    ST_PRIME    = 3'b001,
    ST_RUN      = 3'b010,
    ST_UNDERRUN = 3'b100
  } state_t;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   level_nxt;
  state_t                state;
  state_t                state_nxt;
  logic                  wr_ok;
  logic                  wr_drop;
  logic                  rd_go;
  logic                  starve;
  logic [31:0]           rd_data_p0;
  logic                  vld_p0;
  logic signed [15:0]    rd_i_p0;
  logic signed [15:0]    rd_q_p0;

  assign rd_i_p0 = signed'(rd_data_p0[31:16]);
  assign rd_q_p0 = signed'(rd_data_p0[15:0]);

  // Accept/drop/read decisions use the pre-cycle level; flush overrides all.
  always_comb begin
    wr_ok   = wr_en_i && (level != FULL_LVL) && !flush_i;
    wr_drop = wr_en_i && (level == FULL_LVL) && !flush_i;
    rd_go   = (state == ST_RUN) && sample_en_i && (level != '0) && !flush_i;
    starve  = (state == ST_RUN) && sample_en_i && (level == '0) && !flush_i;
    level_nxt = level;
    case ({wr_ok, rd_go})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Next-state logic; start/restart thresholds look at the post-update level.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PRIME:    if (level_nxt >= START_LVL) state_nxt = ST_RUN;
      ST_RUN:      if (starve) state_nxt = ST_UNDERRUN;
      ST_UNDERRUN: if (level_nxt >= START_LVL) state_nxt = ST_RUN;
      default:     state_nxt = ST_PRIME;
    endcase
    if (flush_i) state_nxt = ST_PRIME;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_PRIME;
    else       state <= state_nxt;
  end

  // Pointers, fill level, sticky flags and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
      level  <= level_nxt;
      vld_p0 <= rd_go;
      if (wr_drop) overflow_o  <= 1'b1;
      if (starve)  underflow_o <= 1'b1;
    end
  end

  // Sample RAM write port.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data_i;
  end

  // Stage p0: synchronous RAM read.
  always_ff @(posedge clk) begin
    if (rd_go) rd_data_p0 <= mem[rd_ptr];
  end

`ifdef DAC_FIFO_HOLD_LAST_EN
  // Stage p1: output register; underrun leaves the last sample in place.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      dac_i_o     <= '0;
      dac_q_o     <= '0;
      dac_valid_o <= 1'b0;
    end else begin
      dac_valid_o <= vld_p0;
      if (vld_p0) begin
        dac_i_o <= rd_i_p0;
        dac_q_o <= rd_q_p0;
      end
    end
  end
`else
  logic und_p0;

  // Underrun marker travels with the read pipeline so ordering is kept.
  always_ff @(posedge clk) begin
    if (reset || flush_i) und_p0 <= 1'b0;
    else                  und_p0 <= starve;
  end

  // Stage p1: output register; underrun parks the DAC at mid-scale.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      dac_i_o     <= '0;
      dac_q_o     <= '0;
      dac_valid_o <= 1'b0;
    end else begin
      dac_valid_o <= vld_p0;
      if (vld_p0) begin
        dac_i_o <= rd_i_p0;
        dac_q_o <= rd_q_p0;
      end else if (und_p0) begin
        dac_i_o <= '0;
        dac_q_o <= '0;
      end
    end
  end
`endif

  assign running_o = (state == ST_RUN);
  assign level_o   = level;

endmodule
